// File: rtl/serial_addsub_seq.sv
// Bit-serial add/subtract sequencer: one full-adder cell, LSB first, one bit per clock.
// Define SERIAL_SUB_EN to honour op_sub (two's-complement subtract); otherwise every job is A+B.

module adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_addsub_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] MSB_CIN_BIT = CNT_W'(WIDTH - 2);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  state_t             state_next;
  logic               accept;
  logic [WIDTH-1:0]   op_reg;
  logic [WIDTH-1:0]   opb_reg;
  logic               carry_reg;
  logic               msb_cin_reg;
  logic [CNT_W-1:0]   bit_cnt;
  logic               b_bit;
  logic               init_carry;
  logic               sum_bit;
  logic               carry_bit;

`ifdef SERIAL_SUB_EN
  logic sub_reg;
  assign b_bit      = opb_reg[0] ^ sub_reg;
  assign init_carry = op_sub;
`else
  logic unused_op_sub;
  assign unused_op_sub = op_sub;
  assign b_bit         = opb_reg[0];
  assign init_carry    = 1'b0;
`endif

  adder u_adder (
    .a    (op_reg[0]),
    .b    (b_bit),
    .cin  (carry_reg),
    .sum  (sum_bit),
    .cout (carry_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Handshake outputs depend on state only; start merely steers the next state.
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (bit_cnt == LAST_BIT) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_reg      <= '0;
      opb_reg     <= '0;
      carry_reg   <= 1'b0;
      msb_cin_reg <= 1'b0;
      bit_cnt     <= '0;
      result      <= '0;
      cout        <= 1'b0;
      ovf         <= 1'b0;
`ifdef SERIAL_SUB_EN
      sub_reg     <= 1'b0;
`endif
    end else if (accept) begin
      op_reg      <= a;
      opb_reg     <= b;
      carry_reg   <= init_carry;
      msb_cin_reg <= 1'b0;
      bit_cnt     <= '0;
      result      <= '0;
      cout        <= 1'b0;
      ovf         <= 1'b0;
`ifdef SERIAL_SUB_EN
      sub_reg     <= op_sub;
`endif
    end else if (busy) begin
      op_reg    <= op_reg >> 1;
      opb_reg   <= opb_reg >> 1;
      result    <= {sum_bit, result[WIDTH-1:1]};
      carry_reg <= carry_bit;
      bit_cnt   <= bit_cnt + CNT_W'(1);
      if (bit_cnt == MSB_CIN_BIT) msb_cin_reg <= carry_bit;
      // Flags are registered on the last bit so they are already valid during DONE.
      if (bit_cnt == LAST_BIT) begin
        cout <= carry_bit;
        ovf  <= msb_cin_reg ^ carry_bit;
      end
    end
  end
endmodule

// File: tb/tb_serial_addsub_seq.sv
// Scoreboard bench for serial_addsub_seq: jobs are predicted at acceptance with plain
// arithmetic and checked by an independent monitor when done is expected.

module tb_serial_addsub_seq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         op_sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         ready, busy, done, cout, ovf;
  logic [W-1:0] result;

  serial_addsub_seq #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op_sub (op_sub),
    .a      (a),
    .b      (b),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         co;
    logic         ov;
    int           acc;
  } exp_t;

  exp_t         q[$];
  int           cyc = 0;
  int           next_free = 0;
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] last_res = '0;
  logic         last_co = 1'b0;
  logic         last_ov = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic sub, input int c);
    exp_t e;
    int   sd;
    logic [W:0] s;
    e.acc = c;
`ifdef SERIAL_SUB_EN
    if (sub) begin
      e.res = x - y;
      e.co  = (x >= y);
      sd    = $signed(x) - $signed(y);
      e.ov  = (sd > (2 ** (W - 1)) - 1) || (sd < -(2 ** (W - 1)));
      return e;
    end
`endif
    s     = {1'b0, x} + {1'b0, y};
    e.res = s[W-1:0];
    e.co  = s[W];
    sd    = $signed(x) + $signed(y);
    e.ov  = (sd > (2 ** (W - 1)) - 1) || (sd < -(2 ** (W - 1)));
    return e;
  endfunction

  // Acceptance: a start seen while the previous job's WIDTH+2 cycle slot has elapsed.
  always @(posedge clk) begin
    if (!rst && start && cyc >= next_free) begin
      q.push_back(model(a, b, op_sub, cyc));
      next_free = cyc + W + 2;
    end
  end

  always @(posedge rst) begin
    q.delete();
    next_free = 0;
    last_res  = '0;
    last_co   = 1'b0;
    last_ov   = 1'b0;
  end

  always @(negedge clk) begin
    if (!rst) begin
      automatic bit exp_done = (q.size() > 0) && (cyc == q[0].acc + W + 1);
      automatic bit free     = (cyc >= next_free);
      check("ready", ready, free);
      check("busy", busy, !free && !exp_done);
      check("done", done, exp_done);
      if (exp_done) begin
        check("result", result, q[0].res);
        check("cout", cout, q[0].co);
        check("ovf", ovf, q[0].ov);
        last_res = q[0].res;
        last_co  = q[0].co;
        last_ov  = q[0].ov;
        void'(q.pop_front());
      end
      if (free) begin
        check("result_hold", result, last_res);
        check("cout_hold", cout, last_co);
        check("ovf_hold", ovf, last_ov);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_free();
    int n = 0;
    while (cyc < next_free && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check("wait_ready_timeout", 32'd1, 32'd0);
  endtask

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic sub,
                       output int acc);
    wait_free();
    start  = 1'b1;
    a      = x;
    b      = y;
    op_sub = sub;
    acc    = cyc;
    tick();
    start  = 1'b0;
    a      = W'($urandom);
    b      = W'($urandom);
    op_sub = 1'($urandom);
  endtask

  task automatic pulse_at(input int target);
    while (cyc < target) tick();
    start  = 1'b1;
    a      = 8'hAA;
    b      = 8'h55;
    op_sub = 1'b0;
    tick();
    start  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    #1;
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    repeat (2) tick();
    rst = 1'b0;
    tick();

    issue(8'h3C, 8'h0F, 1'b0, acc);
    issue(8'hFF, 8'h01, 1'b0, acc);
    issue(8'h7F, 8'h01, 1'b0, acc);
    issue(8'h05, 8'h07, 1'b1, acc);
    issue(8'h80, 8'h01, 1'b1, acc);

    // Requests during RUN and during DONE are dropped.
    issue(8'h10, 8'h20, 1'b0, acc);
    pulse_at(acc + 3);
    pulse_at(acc + 9);

    // Asynchronous reset in the middle of a job.
    issue(8'h3C, 8'h0F, 1'b0, acc);
    while (cyc < acc + 4) tick();
    rst = 1'b1;
    #1;
    check("midrst_ready", ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_result", result, 0);
    check("midrst_cout", cout, 0);
    check("midrst_ovf", ovf, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    issue(8'h01, 8'h01, 1'b0, acc);

    // start held high: back-to-back acceptances every WIDTH+2 cycles.
    wait_free();
    start = 1'b1;
    repeat (32) begin
      a      = W'($urandom);
      b      = W'($urandom);
      op_sub = 1'($urandom);
      tick();
    end
    start = 1'b0;

    for (int i = 0; i < 30; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom), acc);
      repeat ($urandom_range(0, 12)) tick();
    end

    wait_free();
    repeat (3) tick();
    if (q.size() != 0) check("queue_drain", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
